// File: rtl/code_loader_pkg.sv
// Shared definitions for the code memory boot loader: state encodings,
// code memory depth and the default symbol/word/address widths.
package code_loader_pkg;

  localparam int CL_ADDR_WIDTH   = 9;
  localparam int CL_WORD_WIDTH   = 16;
  localparam int CL_NIBBLE_WIDTH = 4;
  localparam int CODE_MEM_DEPTH  = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/code_loader_nibble_assembler.sv
// Shifts accepted nibbles (MSB nibble first) into a word and flags the
// accepting cycle of the last nibble, presenting the completed word then.
module code_loader_nibble_assembler
  import code_loader_pkg::*;
#(
  parameter int NIBBLE_WIDTH = CL_NIBBLE_WIDTH,
  parameter int WORD_WIDTH   = CL_WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_accept,
  input  logic [NIBBLE_WIDTH-1:0] i_nibble,
  output logic [WORD_WIDTH-1:0]   o_word,
  output logic                    o_word_valid
);

  localparam int NIBS  = WORD_WIDTH / NIBBLE_WIDTH;
  localparam int CW    = $clog2(NIBS);
  localparam int SH_W  = WORD_WIDTH - NIBBLE_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]   r_cnt;
  logic [SH_W-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_accept) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
    end
  end

  // Data path carries no reset; only the nibble counter defines word framing.
  always_ff @(posedge clk) begin
    if (i_accept) begin
      r_shift <= {r_shift[SH_W-NIBBLE_WIDTH-1:0], i_nibble};
    end
  end

  assign o_word       = {r_shift, i_nibble};
  assign o_word_valid = i_accept && (r_cnt == CNT_LAST);

endmodule

// File: rtl/code_loader.sv
// Boot-time loader: assembles a nibble stream (length word + program words)
// into code memory and holds the CPU until done. Optional CODE_LOADER_CHECKSUM_EN.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = CL_ADDR_WIDTH,
  parameter int WORD_WIDTH   = CL_WORD_WIDTH,
  parameter int NIBBLE_WIDTH = CL_NIBBLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_start,
  input  logic [NIBBLE_WIDTH-1:0] in_nibble,
  input  logic                    in_valid,
  output logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_mem_addr,
  output logic [WORD_WIDTH-1:0]   out_mem_data,
  output logic                    out_mem_wr_en,
  output logic                    out_cpu_hold,
  output logic                    out_done,
  output logic                    out_error,
  output logic [ADDR_WIDTH:0]     out_word_count
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [WORD_WIDTH-1:0] MAX_LEN  = WORD_WIDTH'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  state_e                r_state;
  logic                  r_ready;
  logic                  r_wr_en;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_len;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_csum;
`endif

  logic                  w_xfer;
  logic                  w_word_valid;
  logic [WORD_WIDTH-1:0] w_word;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_last;

  assign w_xfer      = in_valid & r_ready;
  assign w_count_nxt = r_count + CNT_ONE;
  assign w_last      = (w_count_nxt == r_len);

  code_loader_nibble_assembler #(
    .NIBBLE_WIDTH (NIBBLE_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_accept     (w_xfer),
    .i_nibble     (in_nibble),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_wr_en <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_len   <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (in_start) begin
            r_state <= ST_LEN;
            r_ready <= 1'b1;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (w_word_valid) begin
            if (w_word == '0) begin
              r_state <= ST_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else if (w_word > MAX_LEN) begin
              r_state <= ST_ERROR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_len   <= w_word[CNT_W-1:0];
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_valid) begin
            r_state <= ST_WRITE;
            r_ready <= 1'b0;
            r_wr_en <= 1'b1;
            r_data  <= w_word;
`ifdef CODE_LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ w_word;
`endif
          end
        end
        ST_WRITE: begin
          r_count <= w_count_nxt;
          // Address is held on the final write so L=512 never wraps it to 0.
          if (w_last) begin
`ifdef CODE_LOADER_CHECKSUM_EN
            r_state <= ST_CHECK;
            r_ready <= 1'b1;
`else
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
`endif
          end else begin
            r_addr  <= r_addr + ADDR_ONE;
            r_state <= ST_DATA;
            r_ready <= 1'b1;
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_word_valid) begin
            r_ready <= 1'b0;
            if (w_word == r_csum) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign out_ready      = r_ready;
  assign out_mem_addr   = r_addr;
  assign out_mem_data   = r_data;
  assign out_mem_wr_en  = r_wr_en;
  assign out_cpu_hold   = r_hold;
  assign out_done       = r_done;
  assign out_error      = r_error;
  assign out_word_count = r_count;

endmodule
